// File: rtl/cacheline_adaptor.sv
`default_nettype none
// ============================================================================
//  Module      : cacheline_adaptor
//  Description : Bridges a 256-bit cache line port to a 64-bit burst memory.
//                A line fill becomes a 4-beat burst read, a writeback becomes
//                a 4-beat burst write, and one resp_o pulse is returned to
//                the cache once the whole line has moved. Both directions are
//                fully buffered inside the adaptor.
//
//  Ports (cache side)
//    line_i    [255:0] in  : writeback line
//    line_o    [255:0] out : assembled fill line (read buffer)
//    address_i [31:0]  in  : line address
//    read_i            in  : line read request
//    write_i           in  : line write request
//    resp_o            out : one-cycle completion pulse
//  Ports (memory side)
//    burst_i   [63:0]  in  : read beat
//    burst_o   [63:0]  out : write beat
//    address_o [31:0]  out : burst address
//    read_o            out : burst read request
//    write_o           out : burst write request
//    resp_i            in  : beat strobe, one beat per high cycle
//  Clock/reset : clk rising edge, rst synchronous active-high
//
//  Revision    : 1.0  initial release
// ============================================================================
module cacheline_adaptor #(
    parameter int BEATS = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,

    input  wire logic [255:0] line_i,
    output logic      [255:0] line_o,
    input  wire logic [31:0]  address_i,
    input  wire logic         read_i,
    input  wire logic         write_i,
    output logic              resp_o,

    input  wire logic [63:0]  burst_i,
    output logic      [63:0]  burst_o,
    output logic      [31:0]  address_o,
    output logic              read_o,
    output logic              write_o,
    input  wire logic         resp_i
);

    localparam int         c_cnt_w = $clog2(BEATS);
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [31:0]          r_addr;
    logic [255:0]         r_wline;
    logic [255:0]         r_rline;
    logic [7:0]           w_beat_lsb;
    logic                 w_last_beat;

    // Bit offset of the current beat inside the line (cnt * 64).
    assign w_beat_lsb  = {r_cnt, 6'd0};
    assign w_last_beat = resp_i && (r_cnt == c_last_beat);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Write wins over read when both are requested.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (write_i) begin
                    w_state_next = ST_WRITE;
                end else if (read_i) begin
                    w_state_next = ST_READ;
                end
            end
            ST_READ: begin
                if (w_last_beat) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_WRITE: begin
                if (w_last_beat) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: request latch, beat counter and the two line buffers.
    // The counter wraps 3 -> 0 on the last beat, which coincides with
    // leaving the burst state, so no fifth beat can be taken.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wline <= '0;
            r_rline <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (write_i) begin
                        r_wline <= line_i;
                        r_addr  <= address_i;
                        r_cnt   <= '0;
                    end else if (read_i) begin
                        r_addr  <= address_i;
                        r_cnt   <= '0;
                    end
                end
                ST_READ: begin
                    if (resp_i) begin
                        r_rline[w_beat_lsb +: 64] <= burst_i;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (resp_i) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs are decoded purely from registered state, so no input has
    // a combinational path to any output.
    // ------------------------------------------------------------------
    assign read_o    = (r_state == ST_READ);
    assign write_o   = (r_state == ST_WRITE);
    assign resp_o    = (r_state == ST_DONE);
    assign address_o = r_addr;
    assign burst_o   = r_wline[w_beat_lsb +: 64];
    assign line_o    = r_rline;

endmodule
`default_nettype wire
